serial_slt: RTL and testbench

- Multi-cycle signed less-than unit: accepts two N-bit two's-complement operands over a valid/ready handshake.
- Resolves the compare one bit per clock, LSB-first, using a serial subtract (a + ~b + 1) with a single carry flop.
- Returns lt/eq flags over a valid/ready result handshake.
- Area-cheap replacement for the combinational slt on non-critical datapaths, such as the sequencer's compare-and-branch path. Flag semantics match slt exactly.

---
 rtl/serial_slt.sv | 112 +++++++++++
 tb/tb_serial_slt.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_slt.sv
// Bit-serial signed less-than / equality unit: LSB-first subtract with a single
// carry flop, one operand bit per clock, results returned over valid/ready.
module serial_slt #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_lt,
    output logic         o_eq,
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; operands move on i_valid&o_ready, results on o_valid&i_ready.

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic          carry;
    logic          nz;
    logic [CW-1:0] cnt;

    logic bit_a;
    logic bit_nb;
    logic d;
    logic c_out;
    logic last;

    // One slice of a + ~b + 1; the carry flop starts at 1 to supply the +1.
    always_comb begin
        bit_a  = sa[0];
        bit_nb = ~sb[0];
        d      = bit_a ^ bit_nb ^ carry;
        c_out  = (bit_a & bit_nb) | (bit_a & carry) | (bit_nb & carry);
        last   = (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_lt    <= 1'b0;
            o_eq    <= 1'b0;
            carry   <= 1'b0;
            nz      <= 1'b0;
            cnt     <= '0;
            sa      <= '0;
            sb      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        sa      <= a;
                        sb      <= b;
                        carry   <= 1'b1;
                        nz      <= 1'b0;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    nz    <= nz | d;
                    carry <= c_out;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        // Sign of the difference corrected by signed overflow
                        // (carry into MSB differs from carry out of MSB).
                        o_lt    <= d ^ (carry ^ c_out);
                        o_eq    <= ~(nz | d);
                        o_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_serial_slt.sv
// Bench for serial_slt: an N=2 instance swept exhaustively and an N=32 instance
// for boundaries, backpressure, operand isolation, reset abort and random pairs.
module tb_serial_slt;

    logic clk = 1'b0;
    logic rst_n;

    logic       iv2, ir2, or2, ov2, lt2, eq2;
    logic [1:0] a2, b2, st2;

    logic        iv32, ir32, or32, ov32, lt32, eq32;
    logic [31:0] a32, b32;
    logic [1:0]  st32;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        lt;
        logic        eq;
        int          hold;
    } vec_t;

    vec_t tab32[9];

    serial_slt #(.N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv2), .o_ready(or2), .a(a2), .b(b2),
        .o_valid(ov2), .i_ready(ir2), .o_lt(lt2), .o_eq(eq2), .dbg_state(st2)
    );

    serial_slt #(.N(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .i_valid(iv32), .o_ready(or32), .a(a32), .b(b32),
        .o_valid(ov32), .i_ready(ir32), .o_lt(lt32), .o_eq(eq32), .dbg_state(st32)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_ov(input bit wide);
        return wide ? ov32 : ov2;
    endfunction

    function automatic logic cur_or(input bit wide);
        return wide ? or32 : or2;
    endfunction

    function automatic logic [1:0] cur_res(input bit wide);
        return wide ? {lt32, eq32} : {lt2, eq2};
    endfunction

    task automatic set_ir(input bit wide, input logic v);
        if (wide) ir32 = v;
        else ir2 = v;
    endtask

    // Starts at the falling edge just after the acceptance edge.
    task automatic wait_result(input bit wide, input string tag, input int hold);
        int lat;
        logic [1:0] exp;
        lat = 0;
        while (!cur_ov(wide) && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, wide ? 32 : 2);
        if (!cur_ov(wide)) begin
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        check({tag, " lt/eq"}, cur_res(wide), exp);
        check({tag, " ready in done"}, cur_or(wide), 1'b0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold valid"}, cur_ov(wide), 1'b1);
            check({tag, " hold lt/eq"}, cur_res(wide), exp);
            check({tag, " hold ready"}, cur_or(wide), 1'b0);
        end
        set_ir(wide, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ir(wide, 1'b0);
        check({tag, " ready after pop"}, cur_or(wide), 1'b1);
        check({tag, " valid after pop"}, cur_ov(wide), 1'b0);
    endtask

    // Driver: offer one pair, wait for acceptance, then collect the result.
    task automatic xact(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                        input logic elt, input logic eeq, input int hold, input string tag);
        int t;
        exp_q.push_back({elt, eeq});
        @(negedge clk);
        if (wide) begin a32 = av; b32 = bv; iv32 = 1'b1; end
        else begin a2 = av[1:0]; b2 = bv[1:0]; iv2 = 1'b1; end
        t = 0;
        while (!cur_or(wide) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cur_or(wide)) begin
            check({tag, " accept"}, cur_or(wide), 1'b1);
            iv2 = 1'b0;
            iv32 = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        iv2 = 1'b0;
        iv32 = 1'b0;
        wait_result(wide, tag, hold);
    endtask

    initial begin
        rst_n = 1'b0;
        iv2 = 1'b0; ir2 = 1'b0; a2 = '0; b2 = '0;
        iv32 = 1'b0; ir32 = 1'b0; a32 = '0; b32 = '0;

        tab32[0] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 7};
        tab32[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 0};
        tab32[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 0};
        tab32[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0};
        tab32[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0};
        tab32[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 2};
        tab32[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 0};
        tab32[7] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0};
        tab32[8] = '{32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 0};

        repeat (3) @(negedge clk);
        check("reset ready32", or32, 1'b1);
        check("reset valid32", ov32, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ready32", or32, 1'b1);
        check("post-reset valid32", ov32, 1'b0);
        check("post-reset lt/eq32", {lt32, eq32}, 2'b00);
        check("post-reset ready2", or2, 1'b1);
        check("post-reset lt/eq2", {lt2, eq2}, 2'b00);
        check("post-reset state32", st32, 2'd0);

        // Exhaustive N=2 sweep over {-2..1}^2
        for (int ia = -2; ia <= 1; ia++) begin
            for (int ib = -2; ib <= 1; ib++) begin
                logic [31:0] av, bv;
                av = 32'(ia);
                bv = 32'(ib);
                xact(1'b0, av, bv, ia < ib, ia == ib, 0, $sformatf("n2 a=%0d b=%0d", ia, ib));
            end
        end

        // N=32 boundary table
        for (int i = 0; i < 9; i++)
            xact(1'b1, tab32[i].a, tab32[i].b, tab32[i].lt, tab32[i].eq, tab32[i].hold,
                 $sformatf("n32 vec%0d", i));

        // Operand isolation: a second pair held on the inputs during RUN
        exp_q.push_back(2'b10);
        @(negedge clk);
        a32 = 32'd5; b32 = 32'd9; iv32 = 1'b1;
        check("iso ready before", or32, 1'b1);
        @(posedge clk);
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd5;
        for (int c = 0; c < 31; c++) begin
            check("iso ready in run", or32, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        check("iso state run", st32, 2'd1);
        @(posedge clk);
        @(negedge clk);
        check("iso valid", ov32, 1'b1);
        check("iso lt/eq", {lt32, eq32}, exp_q.pop_front());
        exp_q.push_back(2'b00);
        ir32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ir32 = 1'b0;
        check("iso ready back", or32, 1'b1);
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        check("iso second accepted", or32, 1'b0);
        wait_result(1'b1, "iso second", 0);

        // Reset in the middle of RUN
        @(negedge clk);
        a32 = 32'd1; b32 = 32'd2; iv32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort state run", st32, 2'd1);
        rst_n = 1'b0;
        #1;
        check("abort valid", ov32, 1'b0);
        check("abort ready", or32, 1'b1);
        check("abort state", st32, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort valid after", ov32, 1'b0);
        xact(1'b1, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0, 0, "after abort");

        // Random pairs
        for (int r = 0; r < 512; r++) begin
            logic [31:0] av, bv;
            av = $urandom;
            bv = ($urandom_range(0, 7) == 0) ? av : $urandom;
            if ($urandom_range(0, 5) == 0) bv = av ^ (32'h1 << $urandom_range(0, 31));
            xact(1'b1, av, bv, $signed(av) < $signed(bv), av == bv, 0,
                 $sformatf("rand%0d", r));
        end

        check("queue drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
